// File: rtl/pf_pixel_shifter.sv
// Playfield pixel stage: latches a VRAM tile word, fetches its 4bpp row from ROM, shifts pixels out with fine scroll.
// Latency: tile_ld -> rom_rd next cycle; pixels registered one clk after pix_ce; no backpressure (overrun/underrun flagged).
module pf_pixel_shifter #(
  parameter int ROM_AW = 15,
  parameter int PIX_W  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pix_ce,
  input  logic                line_start,
  input  logic                tile_ld,
  input  logic [9:0]          tile_code,
  input  logic [1:0]          tile_bank,
  input  logic                tile_hflip,
  input  logic [3:0]          tile_color,
  input  logic [2:0]          tile_row,
  input  logic [2:0]          fine_x,
  output logic                rom_rd,
  output logic [ROM_AW-1:0]   rom_addr,
  input  logic [8*PIX_W-1:0]  rom_data,
  input  logic                rom_ack,
  output logic [PIX_W-1:0]    pf_pix,
  output logic [3:0]          pf_col,
  output logic                pf_opaque,
  output logic                underrun,
  output logic                overrun
);

  localparam int ROW_W = 8 * PIX_W;

  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

  state_t             state, state_nxt;
  logic [2:0]         phase;
  logic               reload;
  logic               tile_acc, data_cap, ovr_set, und_set;
  logic               hflip_q;
  logic [3:0]         col_q, shift_col, shift_col_nxt;
  logic [ROW_W-1:0]   hold_row, row_in, shifter, shifter_nxt;

  // Reload point: the phase before this pix_ce's update matches the live fine scroll.
  assign reload = pix_ce && (phase == fine_x);
  assign rom_rd = (state == REQ);

  always_comb begin
    row_in = rom_data;
    if (hflip_q) begin
      for (int i = 0; i < 8; i++)
        row_in[i*PIX_W +: PIX_W] = rom_data[(7-i)*PIX_W +: PIX_W];
    end
  end

  always_comb begin
    state_nxt = state;
    tile_acc  = 1'b0;
    data_cap  = 1'b0;
    ovr_set   = 1'b0;
    case (state)
      IDLE: begin
        if (tile_ld) begin
          tile_acc  = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (rom_ack) begin
          data_cap  = 1'b1;
          state_nxt = HOLD;
        end
        if (tile_ld) ovr_set = 1'b1;
      end
      HOLD: begin
        if (reload) begin
          if (tile_ld) begin
            tile_acc  = 1'b1;
            state_nxt = REQ;
          end else begin
            state_nxt = IDLE;
          end
        end else if (tile_ld) begin
          ovr_set = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // An empty holding register at reload feeds a transparent row and keeps the old colour.
  always_comb begin
    shifter_nxt   = shifter;
    shift_col_nxt = shift_col;
    und_set       = 1'b0;
    if (reload) begin
      if (state == HOLD) begin
        shifter_nxt   = hold_row;
        shift_col_nxt = col_q;
      end else begin
        shifter_nxt = '0;
        und_set     = 1'b1;
      end
    end else if (pix_ce) begin
      shifter_nxt = {shifter[ROW_W-PIX_W-1:0], {PIX_W{1'b0}}};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      phase     <= 3'd0;
      rom_addr  <= '0;
      hflip_q   <= 1'b0;
      col_q     <= 4'd0;
      hold_row  <= '0;
      shifter   <= '0;
      shift_col <= 4'd0;
      pf_pix    <= '0;
      pf_col    <= 4'd0;
      pf_opaque <= 1'b0;
      underrun  <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (pix_ce) begin
        phase     <= line_start ? 3'd0 : phase + 3'd1;
        shifter   <= shifter_nxt;
        shift_col <= shift_col_nxt;
        pf_pix    <= shifter_nxt[ROW_W-1 -: PIX_W];
        pf_col    <= shift_col_nxt;
        pf_opaque <= |shifter_nxt[ROW_W-1 -: PIX_W];
      end
      if (tile_acc) begin
        rom_addr <= {tile_bank, tile_code, tile_row};
        hflip_q  <= tile_hflip;
        col_q    <= tile_color;
      end
      if (data_cap) hold_row <= row_in;
      if (und_set)  underrun <= 1'b1;
      if (ovr_set)  overrun  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pf_pixel_shifter.sv
// Directed bench for pf_pixel_shifter: hand-computed pixel streams, flags and ROM port behaviour.
module tb_pf_pixel_shifter;

  logic        clk = 1'b0;
  logic        rst;
  logic        pix_ce, line_start, tile_ld, tile_hflip, rom_ack;
  logic [9:0]  tile_code;
  logic [1:0]  tile_bank;
  logic [3:0]  tile_color;
  logic [2:0]  tile_row, fine_x;
  logic        rom_rd;
  logic [14:0] rom_addr;
  logic [31:0] rom_data;
  logic [3:0]  pf_pix, pf_col;
  logic        pf_opaque, underrun, overrun;

  int vectors = 0;
  int miscompares = 0;

  pf_pixel_shifter dut (
    .clk(clk), .rst(rst), .pix_ce(pix_ce), .line_start(line_start),
    .tile_ld(tile_ld), .tile_code(tile_code), .tile_bank(tile_bank),
    .tile_hflip(tile_hflip), .tile_color(tile_color), .tile_row(tile_row),
    .fine_x(fine_x), .rom_rd(rom_rd), .rom_addr(rom_addr), .rom_data(rom_data),
    .rom_ack(rom_ack), .pf_pix(pf_pix), .pf_col(pf_col), .pf_opaque(pf_opaque),
    .underrun(underrun), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic load_tile(input logic [9:0] code, input logic [1:0] bank, input logic flip,
                           input logic [3:0] col, input logic [2:0] row);
    @(negedge clk);
    tile_ld = 1'b1; tile_code = code; tile_bank = bank;
    tile_hflip = flip; tile_color = col; tile_row = row;
    @(negedge clk);
    tile_ld = 1'b0;
  endtask

  task automatic ack(input logic [31:0] data);
    int n = 0;
    while (!rom_rd && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!rom_rd) check("ack_wait_rom_rd", 32'd0, 32'd1);
    rom_ack = 1'b1; rom_data = data;
    @(negedge clk);
    rom_ack = 1'b0; rom_data = 32'hDEAD_BEEF;
  endtask

  task automatic pix(input logic ls);
    @(negedge clk);
    pix_ce = 1'b1; line_start = ls;
    @(negedge clk);
    pix_ce = 1'b0; line_start = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Applies pixels first..last of an expected row word, leftmost nibble = pixel 0.
  task automatic row_check(input string tag, input logic [31:0] w, input logic [3:0] c,
                           input int first, input int last);
    logic [3:0] e;
    for (int i = first; i <= last; i++) begin
      pix(1'b0);
      e = w[31-4*i -: 4];
      check($sformatf("%s_pix%0d", tag, i), {28'd0, pf_pix}, {28'd0, e});
      check($sformatf("%s_opq%0d", tag, i), {31'd0, pf_opaque}, {31'd0, (e != 4'd0)});
      check($sformatf("%s_col%0d", tag, i), {28'd0, pf_col}, {28'd0, c});
    end
  endtask

  initial begin
    rst = 1'b0; pix_ce = 0; line_start = 0; tile_ld = 0; tile_hflip = 0; rom_ack = 0;
    tile_code = 0; tile_bank = 0; tile_color = 0; tile_row = 0; fine_x = 0; rom_data = 0;
    repeat (2) @(negedge clk);
    check("rst_rom_rd", {31'd0, rom_rd}, 32'd0);
    check("rst_rom_addr", {17'd0, rom_addr}, 32'd0);
    check("rst_pf_pix", {28'd0, pf_pix}, 32'd0);
    check("rst_flags", {30'd0, underrun, overrun}, 32'd0);
    rst = 1'b1;

    // Normal, flipped and sparse rows back to back at fine_x=0.
    load_tile(10'h155, 2'd2, 1'b0, 4'hA, 3'd5);
    check("t2_rom_rd", {31'd0, rom_rd}, 32'd1);
    check("t2_rom_addr", {17'd0, rom_addr}, 32'h4AAD);
    ack(32'h1234_5678);
    check("t2_rom_rd_drop", {31'd0, rom_rd}, 32'd0);
    row_check("t2", 32'h1234_5678, 4'hA, 0, 0);
    load_tile(10'h155, 2'd2, 1'b1, 4'h5, 3'd5);
    ack(32'h1234_5678);
    row_check("t2", 32'h1234_5678, 4'hA, 1, 7);
    row_check("t3flip", 32'h8765_4321, 4'h5, 0, 0);
    load_tile(10'h020, 2'd1, 1'b0, 4'hC, 3'd0);
    ack(32'h00F0_0000);
    row_check("t3flip", 32'h8765_4321, 4'h5, 1, 7);
    row_check("t3sparse", 32'h00F0_0000, 4'hC, 0, 0);
    load_tile(10'h0AA, 2'd0, 1'b0, 4'h3, 3'd1);
    row_check("t3sparse", 32'h00F0_0000, 4'hC, 1, 7);
    check("t3_no_underrun", {31'd0, underrun}, 32'd0);
    check("t3_no_overrun", {31'd0, overrun}, 32'd0);

    // Ack withheld past the reload: transparent row, old colour, sticky underrun.
    row_check("t5empty", 32'h0, 4'hC, 0, 7);
    check("t5_underrun", {31'd0, underrun}, 32'd1);
    ack(32'h1111_1111);
    row_check("t5late", 32'h1111_1111, 4'h3, 0, 7);
    check("t5_underrun_sticky", {31'd0, underrun}, 32'd1);

    // Fine scroll 3 with line_start from a non-zero phase.
    do_reset();
    fine_x = 3'd3;
    pix(1'b0);
    pix(1'b0);
    load_tile(10'h001, 2'd0, 1'b0, 4'h7, 3'd0);
    ack(32'h1234_5678);
    pix(1'b1);
    check("t4_ls_pix", {28'd0, pf_pix}, 32'd0);
    row_check("t4wait", 32'h0, 4'h0, 0, 2);
    row_check("t4a", 32'h1234_5678, 4'h7, 0, 0);
    load_tile(10'h002, 2'd0, 1'b0, 4'h8, 3'd0);
    ack(32'h9ABC_DEF0);
    row_check("t4a", 32'h1234_5678, 4'h7, 1, 7);
    row_check("t4b", 32'h9ABC_DEF0, 4'h8, 0, 0);
    check("t4_no_underrun", {31'd0, underrun}, 32'd0);

    // Second tile_ld during a fetch is dropped.
    do_reset();
    fine_x = 3'd0;
    load_tile(10'h001, 2'd0, 1'b0, 4'hE, 3'd0);
    load_tile(10'h3FF, 2'd3, 1'b1, 4'h1, 3'd7);
    check("t6_overrun", {31'd0, overrun}, 32'd1);
    check("t6_rom_addr", {17'd0, rom_addr}, 32'h0008);
    check("t6_rom_rd_held", {31'd0, rom_rd}, 32'd1);
    ack(32'hABCD_EF12);
    row_check("t6", 32'hABCD_EF12, 4'hE, 0, 7);
    check("t6_no_refetch", {31'd0, rom_rd}, 32'd0);

    // Asynchronous reset in the middle of a fetch, then a stray ack.
    load_tile(10'h155, 2'd2, 1'b0, 4'h9, 3'd5);
    check("t1_rom_rd_pre", {31'd0, rom_rd}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("t1_rom_rd", {31'd0, rom_rd}, 32'd0);
    check("t1_rom_addr", {17'd0, rom_addr}, 32'd0);
    check("t1_pf", {23'd0, pf_pix, pf_col, pf_opaque}, 32'd0);
    check("t1_flags", {30'd0, underrun, overrun}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    rom_ack = 1'b1; rom_data = 32'hFFFF_FFFF;
    @(negedge clk);
    rom_ack = 1'b0;
    check("t1_stray_ack_rom_rd", {31'd0, rom_rd}, 32'd0);
    pix(1'b0);
    check("t1_stray_ack_pix", {28'd0, pf_pix}, 32'd0);
    check("t1_stray_ack_underrun", {31'd0, underrun}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
